aes_key_sched_ctrl: RTL

//  Sequential AES-128 key-schedule controller and round-key store. Accepts a 128-bit cipher key

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_subword.sv | 17 +
 rtl/aes_key_sched_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, rcon seed, xtime,
// FSM state encoding and the forward S-box.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // GF(2^8) multiply by x, used to advance rcon each round.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] pos;
    pos = 11'd2047 - {x, 3'b000};
    return SBOX_TABLE[pos -: 8];
  endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord(RotWord(w)) for the key schedule: four S-box lookups on a rotated word.
module aes_subword
  import aes_pkg::*;
(
  input  logic [31:0] w_in,
  output logic [31:0] w_out
);

  logic [31:0] rot;

  // Rotate left by one byte, then substitute each byte.
  always_comb begin
    rot   = {w_in[23:0], w_in[31:24]};
    w_out = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: accepts a cipher key, expands one round key
// per cycle into an 11-entry store, and serves registered reads by round index.
// Handshake: a key is taken on any rising edge where key_valid && key_ready;
// key_ready is low only while expanding, and the source must hold key_in
// stable until that edge since it is not latched beforehand.
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [127:0]     key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             busy,
  output logic             keys_valid,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rd_key,
  output logic             rd_hit,
  output logic             rd_err
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t      state_q, state_d;
  logic [3:0]  round_q, round_d;
  logic [7:0]  rcon_q, rcon_d;
  round_key_t  work_q, work_d;
  round_key_t  rk_q [0:NUM_ROUNDS];
  round_key_t  rk_d [0:NUM_ROUNDS];
  logic [127:0] rd_key_q, rd_key_d;
  logic        rd_hit_q, rd_hit_d;
  logic        rd_err_q, rd_err_d;

  logic [31:0] sub_w;
  logic [31:0] temp, n0, n1, n2, n3;
  logic        accept;

  aes_subword u_subword (
    .w_in  (work_q[31:0]),
    .w_out (sub_w)
  );

  // Outputs derived directly from the registered state.
  always_comb begin
    key_ready  = (state_q != ST_EXPAND);
    busy       = (state_q == ST_EXPAND);
    keys_valid = (state_q == ST_DONE);
    rd_key     = rd_key_q;
    rd_hit     = rd_hit_q;
    rd_err     = rd_err_q;
  end

  // Next-state: key accept, one expansion step per cycle, and the read port.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    rcon_d   = rcon_q;
    work_d   = work_q;
    rk_d     = rk_q;
    rd_key_d = rd_key_q;
    rd_hit_d = 1'b0;
    rd_err_d = 1'b0;
    accept   = key_valid && key_ready;

    temp = sub_w ^ {rcon_q, 24'h0};
    n0   = work_q[127:96] ^ temp;
    n1   = work_q[95:64]  ^ n0;
    n2   = work_q[63:32]  ^ n1;
    n3   = work_q[31:0]   ^ n2;

    if (accept) begin
      rk_d[0] = key_in;
      work_d  = key_in;
      state_d = ST_EXPAND;
      round_d = 4'd1;
      rcon_d  = RCON_INIT;
    end else if (state_q == ST_EXPAND) begin
      work_d = {n0, n1, n2, n3};
      for (int i = 1; i <= NUM_ROUNDS; i++) begin
        if (round_q == 4'(i)) rk_d[i] = {n0, n1, n2, n3};
      end
      round_d = round_q + 4'd1;
      rcon_d  = xtime(rcon_q);
      if (round_q == LAST_ROUND) state_d = ST_DONE;
    end

    // Reads see the store as it was before this edge; no write bypass.
    if (rd_en) begin
      rd_key_d = '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) begin
        if (rd_idx == IDX_W'(i)) rd_key_d = rk_q[i];
      end
      rd_err_d = (rd_idx > IDX_W'(AES_NR));
      case (state_q)
        ST_EXPAND: rd_hit_d = (rd_idx < IDX_W'(round_q));
        ST_DONE:   rd_hit_d = (rd_idx <= IDX_W'(AES_NR));
        default:   rd_hit_d = 1'b0;
      endcase
    end
  end

  // State, working register, key store and read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      round_q  <= '0;
      rcon_q   <= RCON_INIT;
      work_q   <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
      rd_key_q <= '0;
      rd_hit_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      rcon_q   <= rcon_d;
      work_q   <= work_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
      rd_key_q <= rd_key_d;
      rd_hit_q <= rd_hit_d;
      rd_err_q <= rd_err_d;
    end
  end

endmodule
